// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT         = 26;
    localparam int unsigned DEFAULT_HALF_50M_1HZ  = 25000000;
    localparam int unsigned DEFAULT_HALF_50M_1MHZ = 25;

    typedef logic [DIV_W_DEFAULT-1:0] half_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, shadowed divisor, toggle and tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W        = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_50M_1HZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    output logic             out_clk,
    output logic             tick,
    output logic             pending
);

    localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(DEFAULT_HALF);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic wr_ok;
    logic terminal;

    assign wr_ok    = div_wr && (div_val != '0);
    assign terminal = (cnt_q == active_q - DIV_W'(1));

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        out_d     = out_q;
        tick_d    = 1'b0;

        if (!en) begin
            cnt_d     = '0;
            out_d     = 1'b0;
            pending_d = 1'b0;
            if (wr_ok) begin
                active_d = div_val;
                shadow_d = div_val;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
        end else if (terminal) begin
            // Period boundary: the only point a new divisor may take effect.
            cnt_d     = '0;
            out_d     = ~out_q;
            tick_d    = ~out_q;
            pending_d = 1'b0;
            if (wr_ok) begin
                active_d = div_val;
                shadow_d = div_val;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (wr_ok) begin
                shadow_d  = div_val;
                pending_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            active_q  <= RESET_HALF;
            shadow_q  <= RESET_HALF;
            pending_q <= 1'b0;
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
        end
    end

    assign out_clk = out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider and tick generator.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIV_W        = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_50M_1HZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] div_wr,
    input  logic [DIV_W-1:0]  div_val,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W        (DIV_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .div_wr  (div_wr[i]),
            .div_val (div_val),
            .out_clk (out_clk[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed-vector bench for clk_div_prog with DEFAULT_HALF=3 on two channels.
module tb_clk_div_prog;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIV_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] div_wr;
    logic [DIV_W-1:0]  div_val;
    logic [NUM_CH-1:0] out_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;

    clk_div_prog #(
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_wr  (div_wr),
        .div_val (div_val),
        .out_clk (out_clk),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Advance one clock; n counts edges since the last reset release.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic restart(input logic [NUM_CH-1:0] en_v);
        rst     = 1'b0;
        en      = '0;
        div_wr  = '0;
        div_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        en  = en_v;
        n   = 0;
    endtask

    task automatic test_reset();
        logic e_out, e_tick;
        rst = 1'b0; en = '0; div_wr = '0; div_val = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_clk !== 2'b00) begin n_err++; $display("FAIL reset_out_clk got %b want 00", out_clk); end
        n_cmp++;
        if (tick !== 2'b00) begin n_err++; $display("FAIL reset_tick got %b want 00", tick); end
        n_cmp++;
        if (pending !== 2'b00) begin n_err++; $display("FAIL reset_pending got %b want 00", pending); end
        rst = 1'b1; en = 2'b11; n = 0;
        for (int k = 0; k < 17; k++) begin
            e_out  = ((n / 3) % 2) == 1;
            e_tick = (n % 6) == 3;
            n_cmp++;
            if (out_clk !== {e_out, e_out}) begin
                n_err++; $display("FAIL default_out n=%0d got %b want %b", n, out_clk, {e_out, e_out});
            end
            n_cmp++;
            if (tick !== {e_tick, e_tick}) begin
                n_err++; $display("FAIL default_tick n=%0d got %b want %b", n, tick, {e_tick, e_tick});
            end
            step();
        end
    endtask

    task automatic test_pending_write();
        logic e_out, e_tick, e_pend, e_out1;
        restart(2'b11);
        repeat (3) step();
        div_wr = 2'b01; div_val = 8'd5;
        step();
        div_wr = 2'b00;
        for (int k = 0; k < 17; k++) begin
            e_out  = (n < 6) || (n >= 11 && n <= 15);
            e_tick = (n == 11);
            e_pend = (n == 4) || (n == 5);
            e_out1 = ((n / 3) % 2) == 1;
            n_cmp++;
            if (out_clk[0] !== e_out) begin n_err++; $display("FAIL pend_out n=%0d got %b want %b", n, out_clk[0], e_out); end
            n_cmp++;
            if (tick[0] !== e_tick) begin n_err++; $display("FAIL pend_tick n=%0d got %b want %b", n, tick[0], e_tick); end
            n_cmp++;
            if (pending !== {1'b0, e_pend}) begin n_err++; $display("FAIL pend_flag n=%0d got %b want %b", n, pending, {1'b0, e_pend}); end
            n_cmp++;
            if (out_clk[1] !== e_out1) begin n_err++; $display("FAIL pend_ch1 n=%0d got %b want %b", n, out_clk[1], e_out1); end
            step();
        end
    endtask

    task automatic test_terminal_write();
        logic e_out, e_tick;
        restart(2'b11);
        repeat (5) step();
        div_wr = 2'b01; div_val = 8'd2;
        step();
        div_wr = 2'b00;
        for (int k = 0; k < 11; k++) begin
            e_out  = (((n - 6) / 2) % 2) == 1;
            e_tick = (n >= 8) && ((n - 8) % 4 == 0);
            n_cmp++;
            if (out_clk[0] !== e_out) begin n_err++; $display("FAIL term_out n=%0d got %b want %b", n, out_clk[0], e_out); end
            n_cmp++;
            if (tick[0] !== e_tick) begin n_err++; $display("FAIL term_tick n=%0d got %b want %b", n, tick[0], e_tick); end
            n_cmp++;
            if (pending[0] !== 1'b0) begin n_err++; $display("FAIL term_pending n=%0d got %b want 0", n, pending[0]); end
            step();
        end
    endtask

    task automatic test_zero_write();
        logic e_out;
        restart(2'b11);
        repeat (3) step();
        div_wr = 2'b01; div_val = 8'd0;
        step();
        div_wr = 2'b00;
        for (int k = 0; k < 12; k++) begin
            e_out = ((n / 3) % 2) == 1;
            n_cmp++;
            if (out_clk[0] !== e_out) begin n_err++; $display("FAIL zero_out n=%0d got %b want %b", n, out_clk[0], e_out); end
            n_cmp++;
            if (pending[0] !== 1'b0) begin n_err++; $display("FAIL zero_pending n=%0d got %b want 0", n, pending[0]); end
            step();
        end
    endtask

    task automatic test_div1();
        logic e_hi;
        restart(2'b11);
        div_wr = 2'b01; div_val = 8'd1;
        step();
        div_wr = 2'b00;
        repeat (2) step();
        for (int k = 0; k < 10; k++) begin
            e_hi = (n % 2) == 1;
            n_cmp++;
            if (out_clk[0] !== e_hi) begin n_err++; $display("FAIL div1_out n=%0d got %b want %b", n, out_clk[0], e_hi); end
            n_cmp++;
            if (tick[0] !== e_hi) begin n_err++; $display("FAIL div1_tick n=%0d got %b want %b", n, tick[0], e_hi); end
            step();
        end
    endtask

    task automatic test_disable();
        logic e_out0, e_out1, e_tick1;
        restart(2'b11);
        repeat (4) step();
        en = 2'b01;
        step();
        n_cmp++;
        if (out_clk !== 2'b01) begin n_err++; $display("FAIL dis_out got %b want 01", out_clk); end
        n_cmp++;
        if (tick[1] !== 1'b0) begin n_err++; $display("FAIL dis_tick got %b want 0", tick[1]); end
        div_wr = 2'b10; div_val = 8'd4;
        step();
        div_wr = 2'b00;
        n_cmp++;
        if (pending[1] !== 1'b0) begin n_err++; $display("FAIL dis_pending got %b want 0", pending[1]); end
        step();
        en = 2'b11;
        for (int k = 0; k < 16; k++) begin
            e_out0  = ((n / 3) % 2) == 1;
            e_out1  = (n >= 11) && (((n - 11) / 4) % 2 == 0);
            e_tick1 = (n >= 11) && ((n - 11) % 8 == 0);
            n_cmp++;
            if (out_clk !== {e_out1, e_out0}) begin
                n_err++; $display("FAIL reen_out n=%0d got %b want %b", n, out_clk, {e_out1, e_out0});
            end
            n_cmp++;
            if (tick[1] !== e_tick1) begin n_err++; $display("FAIL reen_tick n=%0d got %b want %b", n, tick[1], e_tick1); end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic e_out, e_tick;
        restart(2'b11);
        div_wr = 2'b11; div_val = 8'd5;
        step();
        div_wr = 2'b00;
        repeat (3) step();
        n_cmp++;
        if (out_clk !== 2'b11) begin n_err++; $display("FAIL pre_rst_out got %b want 11", out_clk); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_clk, tick, pending} !== 6'b0) begin
            n_err++; $display("FAIL async_rst got %b want 000000", {out_clk, tick, pending});
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_clk, tick, pending} !== 6'b0) begin
            n_err++; $display("FAIL held_rst got %b want 000000", {out_clk, tick, pending});
        end
        rst = 1'b1; n = 0;
        for (int k = 0; k < 15; k++) begin
            e_out  = ((n / 3) % 2) == 1;
            e_tick = (n % 6) == 3;
            n_cmp++;
            if (out_clk !== {e_out, e_out}) begin
                n_err++; $display("FAIL revert_out n=%0d got %b want %b", n, out_clk, {e_out, e_out});
            end
            n_cmp++;
            if (tick !== {e_tick, e_tick}) begin
                n_err++; $display("FAIL revert_tick n=%0d got %b want %b", n, tick, {e_tick, e_tick});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_pending_write();
        test_terminal_write();
        test_zero_write();
        test_div1();
        test_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator.
- Each channel produces a 50% duty square wave plus a one-cycle enable tick, derived from the system clock.
- Replaces fixed compile-time dividers, e.g. the 50 MHz single-step/slow core clock, UART baud strobes and LED/debug blinkers.
- Divisor updates are glitch-free and are applied only on a period boundary.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- DIV_W, 26, width of the half-period count register.
- DEFAULT_HALF, 25000000, half-period count (in clk cycles) loaded into every channel at reset; must be ≥1 and < 2**DIV_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel run enable.
- div_wr  in  NUM_CH  per-channel one-cycle write strobe for div_val.
- div_val  in  DIV_W  new half-period count, shared by all channels.
- out_clk  out  NUM_CH  divided square wave per channel (registered).
- tick  out  NUM_CH  one-cycle pulse coincident with each out_clk rising edge (registered).
- pending  out  NUM_CH  high while a written divisor awaits its period boundary.

Behaviour:
- Reset (rst=0, async) applies to every channel:
  - cnt=0, active_half=DEFAULT_HALF, shadow_half=DEFAULT_HALF.
  - pending=0, out_clk=0, tick=0.
- Terminal count: cnt == active_half-1.
- Running (en=1), each cycle:
  - If not terminal: cnt increments by 1 and tick=0.
  - If terminal: cnt returns to 0 and out_clk toggles.
  - tick=1 in the cycle where out_clk goes 0→1; tick=0 otherwise.
  - Output period = 2*active_half clk cycles.
  - active_half=1 gives clk/2, with tick high every other cycle.
- Divisor write (div_wr[i]=1, div_val≠0):
  - shadow_half ← div_val and pending ← 1.
  - With div_val=0 the write is ignored; shadow and pending are unchanged.
  - Writing several times before a boundary: the last write wins.
- Boundary load (en=1): at a terminal count with pending=1, active_half ← shadow_half and pending ← 0.
  - The new value governs the half-period starting next cycle.
  - Write in the same cycle as a terminal count: div_val goes straight into active_half and pending stays 0.
  - Consequence: no runt or stretched half-period ever mixes two divisors.
- Disabled (en=0):
  - cnt ← 0, out_clk ← 0, tick ← 0.
  - Any pending or same-cycle write is loaded into active_half immediately; pending ← 0.
- Re-enable (en 0→1): first out_clk rise occurs active_half cycles after the first cycle with en=1. Tick is asserted in that cycle.
- Channels are fully independent. One write strobe may target several channels at once.
- Reset asserted mid-period: outputs drop to reset values asynchronously. The programmed divisor is lost and reverts to DEFAULT_HALF.
- Counter width: cnt is DIV_W bits. active_half ≤ 2**DIV_W-1, so cnt never wraps.

Decomposition:
- Package clk_div_pkg holds:
  - constants DEFAULT_HALF_50M_1HZ = 25000000 and DEFAULT_HALF_50M_1MHZ = 25;
  - typedef half_t (logic [DIV_W-1:0] at default width).
- Sub-module clk_div_chan implements one channel: counter, shadow/active registers, pending flag, toggle and tick.
- clk_div_prog is a generate loop of NUM_CH instances.

Test Plan:
- Use DEFAULT_HALF=3, NUM_CH=2, en=11 after reset release:
  - out_clk[0] rises at cycle 3, falls at cycle 6, and has period 6;
  - tick[0] is high only at cycles 3, 9, 15.
- Ch0 running with half=3; at cycle 4 write div_val=5:
  - pending[0]=1 until the terminal at cycle 5;
  - the next high phase is 3 cycles, and the following low and high phases are 5 cycles each;
  - no intermediate-length phase appears.
- Write div_val=2 exactly on a terminal cycle:
  - the next half-period is 2 cycles;
  - pending never asserts.
- Write div_val=0:
  - period unchanged and pending stays 0.
- Write div_val=1: out_clk toggles every cycle and tick is high every 2nd cycle.
- Drop en[1] mid-high phase:
  - out_clk[1]=0 the next cycle while ch0 is unaffected;
  - a write of 4 while disabled applies immediately;
  - after re-enable the first rise comes 4 cycles later.
- Assert rst low mid-period for 1 cycle:
  - all outputs are 0 immediately, without waiting for a clk edge;
  - after release the period reverts to 2*DEFAULT_HALF.
